// File: rtl/cv32e40x_div_seq_if.sv
// Operand, result and ALU-sharing signals of the sequential divider.
// The divider uses the slave modport; the execute-stage integration uses master.
interface cv32e40x_div_seq_if;
   logic        valid_i;
   logic        ready_o;
   logic [1:0]  operator_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic        kill_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic        alu_clz_en_o;
   logic [31:0] alu_clz_data_o;
   logic [5:0]  alu_clz_result_i;
   logic        alu_shift_en_o;
   logic [5:0]  alu_shift_amt_o;
   logic [31:0] alu_op_a_o;
   logic [31:0] alu_shifted_i;

   modport slave (
      input  valid_i, operator_i, op_a_i, op_b_i, kill_i, ready_i,
             alu_clz_result_i, alu_shifted_i,
      output ready_o, valid_o, result_o, alu_clz_en_o, alu_clz_data_o,
             alu_shift_en_o, alu_shift_amt_o, alu_op_a_o
   );

   modport master (
      output valid_i, operator_i, op_a_i, op_b_i, kill_i, ready_i,
             alu_clz_result_i, alu_shifted_i,
      input  ready_o, valid_o, result_o, alu_clz_en_o, alu_clz_data_o,
             alu_shift_en_o, alu_shift_amt_o, alu_op_a_o
   );
endinterface

// File: rtl/cv32e40x_div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, normalising the
// divisor with the ALU's CLZ and barrel shifter instead of private copies.
//
// state | meaning
// IDLE  | ready for a request; zero divisor / zero dividend finish here
// CLZ   | ALU counts leading zeros of |b|
// SHIFT | ALU left-aligns |b| so its MSB is set
// ITER  | one quotient bit per cycle, cnt+1 cycles
// FIN   | apply result signs, select quotient or remainder
// DONE  | result valid, held until accepted
module cv32e40x_div_seq #(
   parameter bit ZERO_DIVIDEND_SHORTCUT = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   cv32e40x_div_seq_if.slave      bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLZ   = 3'd1,
      SHIFT = 3'd2,
      ITER  = 3'd3,
      FIN   = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t      state_q, state_d;

   logic [4:0]  cnt_q;
   logic [31:0] abs_a_q, abs_b_q;
   logic [31:0] d_q, rem_q, quo_q, result_q;
   logic        rem_op_q, neg_quo_q, neg_rem_q;

   logic        accept;
   logic        is_signed;
   logic        div_zero;
   logic        zero_shortcut;
   logic [31:0] abs_a, abs_b;
   logic        rem_ge;
   logic [31:0] rem_diff;
   logic [31:0] final_quo, final_rem;

   logic        ready;
   logic        valid;
   logic        clz_en;
   logic [31:0] clz_data;
   logic        shift_en;
   logic [5:0]  shift_amt;
   logic [31:0] shift_op_a;

   // The ALU reports 32 only for a zero operand, which never reaches it here.
   logic        unused_clz_msb;
   assign unused_clz_msb = bus.alu_clz_result_i[5];

   assign is_signed     = !bus.operator_i[0];
   assign abs_a         = (is_signed && bus.op_a_i[31]) ? -bus.op_a_i : bus.op_a_i;
   assign abs_b         = (is_signed && bus.op_b_i[31]) ? -bus.op_b_i : bus.op_b_i;
   assign div_zero      = (bus.op_b_i == 32'd0);
   assign zero_shortcut = ZERO_DIVIDEND_SHORTCUT && (bus.op_a_i == 32'd0);

   assign rem_ge    = (rem_q >= d_q);
   assign rem_diff  = rem_q - d_q;
   assign final_quo = neg_quo_q ? -quo_q : quo_q;
   assign final_rem = neg_rem_q ? -rem_q : rem_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      ready      = 1'b0;
      valid      = 1'b0;
      clz_en     = 1'b0;
      clz_data   = 32'd0;
      shift_en   = 1'b0;
      shift_amt  = 6'd0;
      shift_op_a = 32'd0;

      unique case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (bus.valid_i && !bus.kill_i) begin
               accept  = 1'b1;
               state_d = (div_zero || zero_shortcut) ? DONE : CLZ;
            end
         end
         CLZ: begin
            clz_en   = 1'b1;
            clz_data = abs_b_q;
            state_d  = SHIFT;
         end
         SHIFT: begin
            shift_en   = 1'b1;
            shift_amt  = {1'b0, cnt_q};
            shift_op_a = abs_b_q;
            state_d    = ITER;
         end
         ITER: begin
            if (cnt_q == 5'd0) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = DONE;
         end
         DONE: begin
            valid = 1'b1;
            if (bus.ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_q != IDLE && bus.kill_i) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= 5'd0;
         abs_a_q   <= 32'd0;
         abs_b_q   <= 32'd0;
         d_q       <= 32'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         result_q  <= 32'd0;
         rem_op_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  rem_op_q  <= bus.operator_i[1];
                  neg_quo_q <= is_signed && (bus.op_a_i[31] ^ bus.op_b_i[31]);
                  neg_rem_q <= is_signed && bus.op_a_i[31];
                  abs_a_q   <= abs_a;
                  abs_b_q   <= abs_b;
                  if (div_zero) begin
                     result_q <= bus.operator_i[1] ? bus.op_a_i : 32'hFFFF_FFFF;
                  end else if (zero_shortcut) begin
                     result_q <= 32'd0;
                  end
               end
            end
            CLZ: begin
               cnt_q <= bus.alu_clz_result_i[4:0];
            end
            SHIFT: begin
               d_q   <= bus.alu_shifted_i;
               rem_q <= abs_a_q;
               quo_q <= 32'd0;
            end
            ITER: begin
               if (rem_ge) begin
                  rem_q <= rem_diff;
               end
               quo_q <= {quo_q[30:0], rem_ge};
               d_q   <= d_q >> 1;
               if (cnt_q != 5'd0) begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            FIN: begin
               // An aborted operation must not disturb the previously held result.
               if (!bus.kill_i) begin
                  result_q <= rem_op_q ? final_rem : final_quo;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ready_o         = ready;
   assign bus.valid_o         = valid;
   assign bus.result_o        = result_q;
   assign bus.alu_clz_en_o    = clz_en;
   assign bus.alu_clz_data_o  = clz_data;
   assign bus.alu_shift_en_o  = shift_en;
   assign bus.alu_shift_amt_o = shift_amt;
   assign bus.alu_op_a_o      = shift_op_a;

endmodule

// File: tb/tb_cv32e40x_div_seq.sv
// Directed bench for the sequential divider: a cycle-level reference model
// checks every cycle, while literal expectations pin results and latencies.
module tb_cv32e40x_div_seq;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   cv32e40x_div_seq_if bus0 ();
   cv32e40x_div_seq_if bus1 ();

   cv32e40x_div_seq #(.ZERO_DIVIDEND_SHORTCUT(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   cv32e40x_div_seq #(.ZERO_DIVIDEND_SHORTCUT(1'b0)) dut_ns (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   function automatic logic [5:0] clz6(input logic [31:0] v);
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) return 6'(31 - i);
      end
      return 6'd32;
   endfunction

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint      sa, sb;
      logic [31:0] q, r;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (op[0]) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end
      return op[1] ? r : q;
   endfunction

   // ALU stand-in: CLZ and left shift of whatever the divider presents.
   assign bus0.alu_clz_result_i = clz6(bus0.alu_clz_data_o);
   assign bus0.alu_shifted_i    = bus0.alu_op_a_o << bus0.alu_shift_amt_o;
   assign bus1.alu_clz_result_i = clz6(bus1.alu_clz_data_o);
   assign bus1.alu_shifted_i    = bus1.alu_op_a_o << bus1.alu_shift_amt_o;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference model: transaction timing derived from clz(|b|)+5 / 1-cycle shortcuts.
   logic        m_busy;
   int          m_cyc;
   int          m_lat;
   logic        m_short;
   logic [31:0] m_res;
   logic [31:0] m_absb;
   logic        e_valid, e_clz, e_sh;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", 32'(bus0.valid_o), 32'd0);
         chk("rst_ready", 32'(bus0.ready_o), 32'd1);
         chk("rst_result", bus0.result_o, 32'd0);
         chk("rst_clz_en", 32'(bus0.alu_clz_en_o), 32'd0);
         chk("rst_shift_en", 32'(bus0.alu_shift_en_o), 32'd0);
         chk("rst_clz_data", bus0.alu_clz_data_o, 32'd0);
         chk("rst_op_a", bus0.alu_op_a_o, 32'd0);
         m_busy = 1'b0;
      end else begin
         e_valid = m_busy && (m_cyc >= m_lat);
         e_clz   = m_busy && !m_short && (m_cyc == 1);
         e_sh    = m_busy && !m_short && (m_cyc == 2);
         chk("m_ready", 32'(bus0.ready_o), 32'(!m_busy));
         chk("m_valid", 32'(bus0.valid_o), 32'(e_valid));
         if (e_valid) chk("m_result", bus0.result_o, m_res);
         chk("m_clz_en", 32'(bus0.alu_clz_en_o), 32'(e_clz));
         chk("m_clz_data", bus0.alu_clz_data_o, e_clz ? m_absb : 32'd0);
         chk("m_shift_en", 32'(bus0.alu_shift_en_o), 32'(e_sh));
         chk("m_shift_amt", 32'(bus0.alu_shift_amt_o), e_sh ? 32'(clz6(m_absb)) : 32'd0);
         chk("m_op_a", bus0.alu_op_a_o, e_sh ? m_absb : 32'd0);
         if (m_busy) begin
            if (bus0.kill_i || (e_valid && bus0.ready_i)) m_busy = 1'b0;
            else m_cyc++;
         end else if (bus0.valid_i && !bus0.kill_i) begin
            m_busy  = 1'b1;
            m_cyc   = 1;
            m_res   = ref_div(bus0.operator_i, bus0.op_a_i, bus0.op_b_i);
            m_absb  = (!bus0.operator_i[0] && bus0.op_b_i[31]) ? -bus0.op_b_i : bus0.op_b_i;
            m_short = (bus0.op_b_i == 32'd0) || (bus0.op_a_i == 32'd0);
            m_lat   = m_short ? 1 : int'(clz6(m_absb)) + 5;
         end
      end
   end

   int          n_clz, n_sh;
   logic [31:0] cap_clz, cap_opa;
   logic [5:0]  cap_amt;

   always @(negedge clk) begin
      if (bus0.alu_clz_en_o) begin
         n_clz++;
         cap_clz = bus0.alu_clz_data_o;
      end
      if (bus0.alu_shift_en_o) begin
         n_sh++;
         cap_amt = bus0.alu_shift_amt_o;
         cap_opa = bus0.alu_op_a_o;
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after valid_o was seen.
   task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input int elat);
      int n;
      bus0.valid_i    = 1'b1;
      bus0.operator_i = op;
      bus0.op_a_i     = a;
      bus0.op_b_i     = b;
      @(posedge clk); #1;
      bus0.valid_i = 1'b0;
      n = 1;
      while (!bus0.valid_o && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_lat"}, 32'(n), 32'(elat));
      chk({nm, "_res"}, bus0.result_o, er);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      total  = 0;
      bad    = 0;
      m_busy = 1'b0;
      n_clz  = 0;
      n_sh   = 0;
      rst    = 1'b1;
      bus0.valid_i = 1'b0; bus0.kill_i = 1'b0; bus0.ready_i = 1'b1;
      bus0.operator_i = 2'b00; bus0.op_a_i = 32'd0; bus0.op_b_i = 32'd0;
      bus1.valid_i = 1'b0; bus1.kill_i = 1'b0; bus1.ready_i = 1'b1;
      bus1.operator_i = 2'b00; bus1.op_a_i = 32'd0; bus1.op_b_i = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      do_op("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
      do_op("remu_100_7",  OP_REMU, 32'd100, 32'd7, 32'd2, 34);
      do_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
      do_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
      do_op("div_7_m2",    OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
      do_op("rem_7_m2",    OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 35);
      do_op("divu_by0",    OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
      do_op("rem_by0",     OP_REM,  32'h1234, 32'd0, 32'h1234, 1);
      do_op("div_0_5",     OP_DIV,  32'd0, 32'd5, 32'd0, 1);
      do_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 36);
      do_op("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 36);
      do_op("divu_max_1",  OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 36);
      do_op("divu_msb",    OP_DIVU, 32'h8000_0000, 32'h8000_0000, 32'd1, 5);
      do_op("remu_msb",    OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 5);

      // ALU borrowing: one CLZ cycle, then one shift cycle
      n_clz = 0;
      n_sh  = 0;
      do_op("divu_if", OP_DIVU, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, 20);
      chk("if_clz_cycles", 32'(n_clz), 32'd1);
      chk("if_clz_data", cap_clz, 32'h0001_0000);
      chk("if_shift_cycles", 32'(n_sh), 32'd1);
      chk("if_shift_amt", 32'(cap_amt), 32'd15);
      chk("if_shift_op_a", cap_opa, 32'h0001_0000);

      // Backpressure: result held while ready_i is low
      bus0.ready_i = 1'b0;
      bus0.valid_i = 1'b1;
      bus0.operator_i = OP_DIV; bus0.op_a_i = 32'd1000; bus0.op_b_i = 32'hFFFF_FFFD;
      @(posedge clk); #1;
      bus0.valid_i = 1'b0;
      n = 1;
      while (!bus0.valid_o && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_lat", 32'(n), 32'd35);
      for (int i = 0; i < 3; i++) begin
         chk("bp_result", bus0.result_o, 32'hFFFF_FEB3);
         chk("bp_ready", 32'(bus0.ready_o), 32'd0);
         chk("bp_valid", 32'(bus0.valid_o), 32'd1);
         @(posedge clk); #1;
      end
      bus0.ready_i = 1'b1;
      @(posedge clk); #1;
      chk("bp_released", 32'(bus0.ready_o), 32'd1);

      // kill_i alongside valid_i in IDLE must not start an operation
      bus0.valid_i = 1'b1; bus0.kill_i = 1'b1;
      bus0.operator_i = OP_DIVU; bus0.op_a_i = 32'd100; bus0.op_b_i = 32'd7;
      @(posedge clk); #1;
      bus0.valid_i = 1'b0; bus0.kill_i = 1'b0;
      chk("kill_idle_ready", 32'(bus0.ready_o), 32'd1);
      chk("kill_idle_clz", 32'(bus0.alu_clz_en_o), 32'd0);

      // kill_i during ITER, then an immediate new request
      bus0.valid_i = 1'b1;
      @(posedge clk); #1;
      bus0.valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #1 bus0.kill_i = 1'b1;
      @(posedge clk); #1;
      bus0.kill_i = 1'b0;
      chk("kill_iter_ready", 32'(bus0.ready_o), 32'd1);
      chk("kill_iter_valid", 32'(bus0.valid_o), 32'd0);
      do_op("after_kill", OP_REMU, 32'd1000, 32'd33, 32'd10, 31);

      // rst pulse during ITER
      bus0.valid_i = 1'b1;
      bus0.operator_i = OP_DIVU; bus0.op_a_i = 32'd500; bus0.op_b_i = 32'd3;
      @(posedge clk); #1;
      bus0.valid_i = 1'b0;
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_result", bus0.result_o, 32'd0);
      chk("rst_mid_ready", 32'(bus0.ready_o), 32'd1);
      chk("rst_mid_valid", 32'(bus0.valid_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_op("after_rst", OP_DIVU, 32'd500, 32'd3, 32'd166, 35);

      // Without the shortcut a zero dividend goes through the full iteration
      bus1.valid_i = 1'b1;
      bus1.operator_i = OP_DIV; bus1.op_a_i = 32'd0; bus1.op_b_i = 32'd5;
      @(posedge clk); #1;
      bus1.valid_i = 1'b0;
      n = 1;
      while (!bus1.valid_o && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ns_zero_lat", 32'(n), 32'd34);
      chk("ns_zero_res", bus1.result_o, 32'd0);
      @(posedge clk); #1;
      chk("ns_ready", 32'(bus1.ready_o), 32'd1);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
